// File: rtl/solitaire_move_ctrl.sv
// solitaire_move_ctrl
// Move sequencer between the player's push-buttons and the peg-solitaire board.
// It keeps a cursor and a select/arm state machine. For each attempted move it
// drives piece_x/piece_y/direction to the board for exactly one cycle. The rest
// of the time those outputs are parked on (0,0,LEFT), where the board cannot act.
// After the attempt it compares the board's piece_count with the count saved
// before the move. It then pulses move_ok or move_bad and keeps an
// accepted-move count.
//
// state  | meaning
// -------+------------------------------------------------------------
// CURSOR | idle; buttons move the cursor, sel arms the piece
// ARMED  | piece selected; a direction button launches a move attempt
// ISSUE  | move presented to the board for exactly one cycle
// CHECK  | board result evaluated against the saved piece count
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   btn_up/down/left/right       single-cycle cursor / direction pulses
//   btn_sel, btn_cancel          arm-disarm pulse, return-to-cursor pulse
//   board_count, board_over      piece_count and game_over from the board
//   piece_x, piece_y, direction  move request to the board (parked when idle)
//   cursor_x, cursor_y, armed    display state
//   move_ok, move_bad            one-cycle result pulses
//   moves                        saturating accepted-move counter
//   locked                       game over; sel is ignored
module solitaire_move_ctrl #(
    parameter logic [2:0] CURSOR_RST_X = 3'd3,
    parameter logic [2:0] CURSOR_RST_Y = 3'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic       btn_cancel,
    input  logic [5:0] board_count,
    input  logic       board_over,
    output logic [2:0] piece_x,
    output logic [2:0] piece_y,
    output logic [1:0] direction,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       armed,
    output logic       move_ok,
    output logic       move_bad,
    output logic [5:0] moves,
    output logic       locked
);

    typedef enum logic [1:0] {S_CURSOR, S_ARMED, S_ISSUE, S_CHECK} state_t;

    localparam logic [1:0] DIR_LEFT  = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    state_t     state, state_nx;
    logic [1:0] dir_q, dir_nx;
    logic [5:0] saved_count, saved_nx;
    logic [2:0] cursor_x_nx, cursor_y_nx;
    logic [2:0] piece_x_nx, piece_y_nx;
    logic [1:0] direction_nx;
    logic       armed_nx, move_ok_nx, move_bad_nx, locked_nx;
    logic [5:0] moves_nx;

    // cancel and sel pre-empt every movement button
    logic ctl_btn, dir_btn;
    assign ctl_btn = btn_cancel | btn_sel;
    assign dir_btn = btn_up | btn_down | btn_left | btn_right;

    // landing square: cursor +/-2 along the latched direction, 4-bit signed
    logic signed [3:0] land_dx, land_dy, land_x_s, land_y_s;
    always_comb begin
        land_dx = 4'sd0;
        land_dy = 4'sd0;
        case (dir_q)
            DIR_LEFT:  land_dx = -4'sd2;
            DIR_RIGHT: land_dx =  4'sd2;
            DIR_UP:    land_dy = -4'sd2;
            default:   land_dy =  4'sd2;
        endcase
        land_x_s = $signed({1'b0, cursor_x}) + land_dx;
        land_y_s = $signed({1'b0, cursor_y}) + land_dy;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_CURSOR;
        else     state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_CURSOR: if (!btn_cancel && btn_sel && !locked) state_nx = S_ARMED;
            S_ARMED: begin
                if (ctl_btn)      state_nx = S_CURSOR;
                else if (dir_btn) state_nx = S_ISSUE;
            end
            S_ISSUE: state_nx = S_CHECK;
            default: state_nx = S_CURSOR;
        endcase
    end

    // output / datapath next values
    always_comb begin
        cursor_x_nx = cursor_x;
        cursor_y_nx = cursor_y;
        dir_nx      = dir_q;
        saved_nx    = saved_count;
        moves_nx    = moves;
        locked_nx   = locked;
        move_ok_nx  = 1'b0;
        move_bad_nx = 1'b0;
        case (state)
            S_CURSOR: begin
                locked_nx = locked | board_over;
                if (!ctl_btn) begin
                    if (btn_up) begin
                        if (cursor_y != 3'd0) cursor_y_nx = cursor_y - 3'd1;
                    end else if (btn_down) begin
                        if (cursor_y < 3'd6) cursor_y_nx = cursor_y + 3'd1;
                    end else if (btn_left) begin
                        if (cursor_x != 3'd0) cursor_x_nx = cursor_x - 3'd1;
                    end else if (btn_right) begin
                        if (cursor_x < 3'd6) cursor_x_nx = cursor_x + 3'd1;
                    end
                end
            end
            S_ARMED: begin
                if (!ctl_btn && dir_btn) begin
                    if (btn_up)        dir_nx = DIR_UP;
                    else if (btn_down) dir_nx = DIR_DOWN;
                    else if (btn_left) dir_nx = DIR_LEFT;
                    else               dir_nx = DIR_RIGHT;
                    saved_nx = board_count;
                end
            end
            S_CHECK: begin
                locked_nx = locked | board_over;
                if (board_count == saved_count - 6'd1) begin
                    move_ok_nx  = 1'b1;
                    if (moves != 6'd63) moves_nx = moves + 6'd1;
                    cursor_x_nx = land_x_s[2:0];
                    cursor_y_nx = land_y_s[2:0];
                end else begin
                    move_bad_nx = 1'b1;
                end
            end
            default: ;
        endcase

        // board inputs leave the parked corner only for the ISSUE cycle
        piece_x_nx   = 3'd0;
        piece_y_nx   = 3'd0;
        direction_nx = DIR_LEFT;
        if (state_nx == S_ISSUE) begin
            piece_x_nx   = cursor_x;
            piece_y_nx   = cursor_y;
            direction_nx = dir_nx;
        end
        // a piece stays selected until the attempt has been evaluated
        armed_nx = (state_nx != S_CURSOR);
    end

    // output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_x    <= CURSOR_RST_X;
            cursor_y    <= CURSOR_RST_Y;
            dir_q       <= DIR_LEFT;
            saved_count <= 6'd0;
            piece_x     <= 3'd0;
            piece_y     <= 3'd0;
            direction   <= DIR_LEFT;
            armed       <= 1'b0;
            move_ok     <= 1'b0;
            move_bad    <= 1'b0;
            moves       <= 6'd0;
            locked      <= 1'b0;
        end else begin
            cursor_x    <= cursor_x_nx;
            cursor_y    <= cursor_y_nx;
            dir_q       <= dir_nx;
            saved_count <= saved_nx;
            piece_x     <= piece_x_nx;
            piece_y     <= piece_y_nx;
            direction   <= direction_nx;
            armed       <= armed_nx;
            move_ok     <= move_ok_nx;
            move_bad    <= move_bad_nx;
            moves       <= moves_nx;
            locked      <= locked_nx;
        end
    end

endmodule

// File: tb/tb_solitaire_move_ctrl.sv
// Directed bench for solitaire_move_ctrl with a small behavioural peg board.
module tb_solitaire_move_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right, btn_sel, btn_cancel;
    logic [5:0] board_count;
    logic       board_over;
    logic [2:0] piece_x, piece_y, cursor_x, cursor_y;
    logic [1:0] direction;
    logic       armed, move_ok, move_bad, locked;
    logic [5:0] moves;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    solitaire_move_ctrl #(.CURSOR_RST_X(3'd3), .CURSOR_RST_Y(3'd3)) dut (
        .clk(clk), .rst(rst),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_sel(btn_sel), .btn_cancel(btn_cancel),
        .board_count(board_count), .board_over(board_over),
        .piece_x(piece_x), .piece_y(piece_y), .direction(direction),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .armed(armed),
        .move_ok(move_ok), .move_bad(move_bad), .moves(moves), .locked(locked)
    );

    // behavioural English-cross board: 33 holes, centre empty, 32 pegs
    logic occ [0:6][0:6];

    function automatic bit on_board(int x, int y);
        return (x >= 0 && x <= 6 && y >= 0 && y <= 6) &&
               ((x >= 2 && x <= 4) || (y >= 2 && y <= 4));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int x = 0; x < 7; x++)
                for (int y = 0; y < 7; y++)
                    occ[x][y] <= on_board(x, y) && !(x == 3 && y == 3);
            board_count <= 6'd32;
        end else begin
            int sx, sy, ddx, ddy, mx, my, tx, ty;
            sx = int'(piece_x); sy = int'(piece_y);
            ddx = 0; ddy = 0;
            case (direction)
                2'd0: ddx = -1;
                2'd1: ddx = 1;
                2'd2: ddy = -1;
                default: ddy = 1;
            endcase
            mx = sx + ddx; my = sy + ddy;
            tx = sx + 2 * ddx; ty = sy + 2 * ddy;
            if (on_board(sx, sy) && on_board(tx, ty)) begin
                if (occ[sx][sy] && occ[mx][my] && !occ[tx][ty]) begin
                    occ[sx][sy] <= 1'b0;
                    occ[mx][my] <= 1'b0;
                    occ[tx][ty] <= 1'b1;
                    board_count <= board_count - 6'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one clock edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_btns();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        btn_sel = 0; btn_cancel = 0;
    endtask

    // buttons: {cancel, sel, up, down, left, right}, held for exactly one edge
    task automatic press(input logic [5:0] b);
        {btn_cancel, btn_sel, btn_up, btn_down, btn_left, btn_right} = b;
        tick();
        clr_btns();
    endtask

    localparam logic [5:0] B_CAN = 6'b100000, B_SEL = 6'b010000, B_UP = 6'b001000,
                           B_DN  = 6'b000100, B_LT  = 6'b000010, B_RT = 6'b000001;

    task automatic check_reset_state(input string tag);
        check({tag, "_cx"}, 32'(cursor_x), 3);
        check({tag, "_cy"}, 32'(cursor_y), 3);
        check({tag, "_armed"}, 32'(armed), 0);
        check({tag, "_ok"}, 32'(move_ok), 0);
        check({tag, "_bad"}, 32'(move_bad), 0);
        check({tag, "_moves"}, 32'(moves), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_park"}, {24'd0, piece_x, piece_y, direction}, 0);
    endtask

    initial begin
        clr_btns();
        board_over = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        check_reset_state("reset");
        check("reset_board", 32'(board_count), 32);

        // legal move: (3,1) DOWN jumps over (3,2) into empty centre
        press(B_UP); press(B_UP);
        check("cur_y_at_1", 32'(cursor_y), 1);
        press(B_SEL);
        check("armed_sel", 32'(armed), 1);
        check("armed_park", {24'd0, piece_x, piece_y, direction}, 0);
        press(B_DN);
        check("issue_coords", {24'd0, piece_x, piece_y, direction}, {3'd3, 3'd1, 2'd3});
        tick();
        check("check_park", {24'd0, piece_x, piece_y, direction}, 0);
        check("check_no_ok", 32'(move_ok), 0);
        check("board_31", 32'(board_count), 31);
        tick();
        check("ok_pulse", 32'(move_ok), 1);
        check("ok_nobad", 32'(move_bad), 0);
        check("moves_1", 32'(moves), 1);
        check("land_xy", {26'd0, cursor_x, cursor_y}, {3'd3, 3'd3});
        check("ok_disarm", 32'(armed), 0);
        tick();
        check("ok_oneshot", 32'(move_ok), 0);

        // same move again: source now empty, board refuses
        press(B_UP); press(B_UP); press(B_SEL); press(B_DN);
        tick(); tick();
        check("bad_pulse", 32'(move_bad), 1);
        check("bad_no_ok", 32'(move_ok), 0);
        check("bad_moves", 32'(moves), 1);
        check("bad_cursor", {26'd0, cursor_x, cursor_y}, {3'd3, 3'd1});
        check("bad_board", 32'(board_count), 31);
        tick();
        check("bad_oneshot", 32'(move_bad), 0);

        // left x5 from (3,3): saturates at 0, board inputs stay parked
        press(B_DN); press(B_DN);
        for (int i = 0; i < 5; i++) begin
            press(B_LT);
            check("left_park", {24'd0, piece_x, piece_y, direction}, 0);
        end
        check("left_sat", 32'(cursor_x), 0);
        press(B_UP | B_LT);
        check("prio_up_over_left", {26'd0, cursor_x, cursor_y}, {3'd0, 3'd2});

        // sel then sel: no ISSUE cycle
        press(B_SEL);
        check("sel1_armed", 32'(armed), 1);
        press(B_SEL);
        check("sel2_disarm", 32'(armed), 0);
        check("sel2_park", {24'd0, piece_x, piece_y, direction}, 0);
        // direction + sel while armed resolves to sel
        press(B_SEL); press(B_SEL | B_DN);
        check("dirsel_disarm", 32'(armed), 0);
        check("dirsel_park", {24'd0, piece_x, piece_y, direction}, 0);
        tick(); tick();
        check("dirsel_no_bad", 32'(move_bad), 0);
        check("sel_board", 32'(board_count), 31);

        // cancel + sel in CURSOR: stays in CURSOR
        press(B_CAN | B_SEL);
        check("cansel_armed", 32'(armed), 0);
        // game over locks out sel but not movement
        board_over = 1;
        tick();
        check("locked_set", 32'(locked), 1);
        board_over = 0;
        press(B_SEL);
        check("locked_sel", 32'(armed), 0);
        press(B_RT);
        check("locked_move", 32'(cursor_x), 1);
        check("locked_sticky", 32'(locked), 1);

        // reset during ISSUE
        rst = 1; tick(); rst = 0;
        check("rst_clears_lock", 32'(locked), 0);
        press(B_UP); press(B_UP); press(B_SEL); press(B_DN);
        check("issue2_coords", {24'd0, piece_x, piece_y, direction}, {3'd3, 3'd1, 2'd3});
        rst = 1; tick(); rst = 0;
        check_reset_state("rst_issue");
        check("rst_issue_board", 32'(board_count), 32);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_pulse", {30'd0, move_ok, move_bad}, 0);
            check("rst_idle_armed", 32'(armed), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
